// File: rtl/lvda_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvda_pio_pkg
// Description : Shared types and widths for the LVDA process-I/O sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package lvda_pio_pkg;

    localparam int c_lvdc_word_w = 26;
    localparam int c_pio_addr_w  = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DONE   = 3'd4
    } pio_state_t;

endpackage
`default_nettype wire

// File: rtl/lvda_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lvda_rr_arbiter
// Description : Combinational round-robin pick: first set request at or above
//               the pointer, wrapping. One-hot grant plus binary index.
// Revision    : 1.0  initial release
// ============================================================================
module lvda_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_grant_idx
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_valid     = 1'b0;
        o_grant     = '0;
        o_grant_idx = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr and i are both below NREQ, so one subtraction wraps the sum
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lvda_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lvda_pio_sequencer
// Description : Arbitrates requesters onto the LVDA PIO channel, drives the
//               address/strobe sequence and shifts in the serial reply word.
// Revision    : 1.0  initial release
// ============================================================================
module lvda_pio_sequencer
    import lvda_pio_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int DATA_BITS  = c_lvdc_word_w,
    parameter int BIT_CYC    = 8
) (
    input  logic                         SIM_CLK,
    input  logic                         SIM_RST,
    input  logic [NREQ-1:0]              REQ,
    input  logic [c_pio_addr_w*NREQ-1:0] REQ_ADDR,
    input  logic [NREQ-1:0]              REQ_AI3,
    output logic [NREQ-1:0]              GRANT,
    output logic                         ACK,
    output logic [DATA_BITS-1:0]         RDATA,
    output logic                         BUSY,
    output logic [c_pio_addr_w-1:0]      ADDR_V,
    output logic                         AI3V,
    output logic                         PIOV,
    input  logic                         DATAV
);

    localparam int c_ptr_w   = $clog2(NREQ);
    localparam int c_cnt_max = (SETUP_CYC > STROBE_CYC)
                             ? ((SETUP_CYC > BIT_CYC) ? SETUP_CYC : BIT_CYC)
                             : ((STROBE_CYC > BIT_CYC) ? STROBE_CYC : BIT_CYC);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_bit_w   = $clog2(DATA_BITS + 1);

    localparam logic [c_cnt_w-1:0] c_setup_last  = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_last = c_cnt_w'(STROBE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_bitcyc_last = c_cnt_w'(BIT_CYC - 1);
    localparam logic [c_bit_w-1:0] c_bit_last    = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last    = c_ptr_w'(NREQ - 1);

    pio_state_t                r_state;
    pio_state_t                w_state_nx;
    logic [c_ptr_w-1:0]        r_ptr;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_bit_w-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0]      r_shift;
    logic [DATA_BITS-1:0]      r_rdata;
    logic [NREQ-1:0]           r_grant;
    logic [c_pio_addr_w-1:0]   r_addr;
    logic                      r_ai3;
    logic                      r_piov;
    logic                      r_ack;

    logic                      w_arb_valid;
    logic [NREQ-1:0]           w_arb_grant;
    logic [c_ptr_w-1:0]        w_arb_idx;
    logic [c_pio_addr_w-1:0]   w_sel_addr;
    logic                      w_sel_ai3;
    logic                      w_sample;

    lvda_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (c_ptr_w)
    ) u_arb (
        .i_req       (REQ),
        .i_ptr       (r_ptr),
        .o_valid     (w_arb_valid),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    // One-hot mux of the winning requester's address and qualifier
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_addr = w_sel_addr
                       | (REQ_ADDR[i*c_pio_addr_w +: c_pio_addr_w] & {c_pio_addr_w{w_arb_grant[i]}});
        end
        w_sel_ai3 = |(REQ_AI3 & w_arb_grant);
    end

    assign w_sample = (r_state == ST_SHIFT) && (r_cnt == c_bitcyc_last);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (w_arb_valid)                  w_state_nx = ST_SETUP;
            ST_SETUP:  if (r_cnt == c_setup_last)        w_state_nx = ST_STROBE;
            ST_STROBE: if (r_cnt == c_strobe_last)       w_state_nx = ST_SHIFT;
            ST_SHIFT:  if (w_sample && r_bit_cnt == c_bit_last) w_state_nx = ST_DONE;
            ST_DONE:                                     w_state_nx = ST_IDLE;
            default:                                     w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rdata   <= '0;
            r_grant   <= '0;
            r_addr    <= '0;
            r_ai3     <= 1'b0;
            r_piov    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_state <= w_state_nx;

            if (w_state_nx != r_state) begin
                r_cnt     <= '0;
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_cnt     <= '0;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (r_state != ST_IDLE) begin
                r_cnt     <= r_cnt + 1'b1;
            end

            if (w_sample) begin
                r_shift <= {r_shift[DATA_BITS-2:0], DATAV};
            end
            // Capture includes the final bit so RDATA is valid in the ACK cycle
            if (r_state == ST_SHIFT && w_state_nx == ST_DONE) begin
                r_rdata <= {r_shift[DATA_BITS-2:0], DATAV};
            end

            if (r_state == ST_IDLE && w_arb_valid) begin
                r_grant <= w_arb_grant;
                r_addr  <= w_sel_addr;
                r_ai3   <= w_sel_ai3;
                r_ptr   <= (w_arb_idx == c_ptr_last) ? '0 : w_arb_idx + 1'b1;
            end else if (r_state == ST_DONE) begin
                r_grant <= '0;
                r_addr  <= '0;
                r_ai3   <= 1'b0;
            end

            r_piov <= (w_state_nx == ST_STROBE);
            r_ack  <= (w_state_nx == ST_DONE);
        end
    end

    assign GRANT  = r_grant;
    assign ACK    = r_ack;
    assign RDATA  = r_rdata;
    assign BUSY   = (r_state != ST_IDLE);
    assign ADDR_V = r_addr;
    assign AI3V   = r_ai3;
    assign PIOV   = r_piov;

endmodule
`default_nettype wire

// File: tb/tb_lvda_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvda_pio_sequencer
// Description : Directed self-checking bench for lvda_pio_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lvda_pio_sequencer;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic [3:0]  REQ;
    logic [35:0] REQ_ADDR;
    logic [3:0]  REQ_AI3;
    logic [3:0]  GRANT;
    logic        ACK;
    logic [25:0] RDATA;
    logic        BUSY;
    logic [8:0]  ADDR_V;
    logic        AI3V;
    logic        PIOV;
    logic        DATAV;

    int n_tests = 0;
    int n_fail  = 0;

    logic [25:0] last_rdata;
    logic [8:0]  addr_tab [4] = '{9'h0A5, 9'h111, 9'h122, 9'h1C3};
    logic [25:0] word_tab [4] = '{26'h2AAAAAA, 26'h1555555, 26'h0ABCDEF, 26'h3123456};
    logic [3:0]  ai3_tab      = 4'b0101;

    always #5 SIM_CLK = ~SIM_CLK;

    lvda_pio_sequencer dut (
        .SIM_CLK  (SIM_CLK),
        .SIM_RST  (SIM_RST),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .REQ_AI3  (REQ_AI3),
        .GRANT    (GRANT),
        .ACK      (ACK),
        .RDATA    (RDATA),
        .BUSY     (BUSY),
        .ADDR_V   (ADDR_V),
        .AI3V     (AI3V),
        .PIOV     (PIOV),
        .DATAV    (DATAV)
    );

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(GRANT),  32'h0);
        chk({tag, "_ack"},   32'(ACK),    32'h0);
        chk({tag, "_rdata"}, 32'(RDATA),  32'h0);
        chk({tag, "_busy"},  32'(BUSY),   32'h0);
        chk({tag, "_addr"},  32'(ADDR_V), 32'h0);
        chk({tag, "_ai3"},   32'(AI3V),   32'h0);
        chk({tag, "_piov"},  32'(PIOV),   32'h0);
    endtask

    task automatic do_reset();
        SIM_RST = 1'b1;
        tick();
        SIM_RST = 1'b0;
        last_rdata = '0;
        chk_zero("reset");
    endtask

    // Present REQ and wait (bounded) for a grant; latency must be one cycle
    task automatic wait_grant(input logic [3:0] req_val, input bit pulse);
        int lat;
        lat = 0;
        REQ = req_val;
        do begin
            tick();
            lat++;
            if (pulse) REQ = '0;
        end while (GRANT == '0 && lat < 20);
        chk("grant_latency", 32'(lat), 32'd1);
    endtask

    // Called in the grant cycle; walks the transaction cycle by cycle while
    // serving DATAV MSB first, one bit per 8-cycle period from cycle 6.
    task automatic run_txn(input logic [1:0] ridx, input logic [25:0] word,
                           input int stop_cyc, input int chg_cyc);
        int          last;
        logic [25:0] sh;
        logic [3:0]  eg;
        last = (stop_cyc >= 0) ? stop_cyc : 214;
        sh   = word;
        eg   = 4'b0001 << ridx;
        for (int c = 0; c <= last; c++) begin
            if (c >= 6 && c < 214) begin
                DATAV = sh[25];
                if ((c - 6) % 8 == 7) sh = {sh[24:0], 1'b0};
            end
            if (c == chg_cyc) REQ_ADDR = ~REQ_ADDR;
            chk("grant",  32'(GRANT),  32'(eg));
            chk("addr_v", 32'(ADDR_V), 32'(addr_tab[ridx]));
            chk("ai3v",   32'(AI3V),   32'(ai3_tab[ridx]));
            chk("piov",   32'(PIOV),   32'(c >= 2 && c <= 5));
            chk("ack",    32'(ACK),    32'(c == 214));
            chk("busy",   32'(BUSY),   32'd1);
            chk("rdata",  32'(RDATA),  32'((c == 214) ? word : last_rdata));
            if (c < last) tick();
        end
        if (stop_cyc < 0) begin
            last_rdata = word;
            tick();
            chk("post_grant", 32'(GRANT),  32'h0);
            chk("post_addr",  32'(ADDR_V), 32'h0);
            chk("post_ai3",   32'(AI3V),   32'h0);
            chk("post_ack",   32'(ACK),    32'h0);
            chk("post_busy",  32'(BUSY),   32'h0);
            chk("post_rdata", 32'(RDATA),  32'(word));
        end
    endtask

    initial begin
        int acks;
        SIM_RST    = 1'b1;
        REQ        = '0;
        REQ_ADDR   = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        REQ_AI3    = ai3_tab;
        DATAV      = 1'b0;
        last_rdata = '0;
        tick();
        tick();
        SIM_RST = 1'b0;
        chk_zero("init");

        // Single request from requester 0
        wait_grant(4'b0001, 1'b1);
        run_txn(2'd0, 26'h2AAAAAA, -1, -1);

        // Contention: all four held, order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wait_grant(4'b1111, 1'b0);
            if (i == 4) REQ = '0;
            run_txn(2'(i % 4), word_tab[i % 4], -1, -1);
        end

        // Fairness: two held, alternating 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_grant(4'b0011, 1'b0);
            if (i == 3) REQ = '0;
            run_txn(2'(i % 2), word_tab[i % 2], -1, -1);
        end

        // Dropped request with address disturbed mid-SHIFT
        wait_grant(4'b0100, 1'b1);
        run_txn(2'd2, 26'h1234567, -1, 100);
        REQ_ADDR = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        tick();
        chk("drop_no_regrant", 32'(GRANT), 32'h0);

        // Reset during reply bit 10
        wait_grant(4'b1000, 1'b1);
        run_txn(2'd3, word_tab[3], 90, -1);
        SIM_RST = 1'b1;
        tick();
        SIM_RST = 1'b0;
        last_rdata = '0;
        chk_zero("abort");
        acks = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (ACK !== 1'b0 || BUSY !== 1'b0) acks++;
        end
        chk("abort_quiet", 32'(acks), 32'd0);
        wait_grant(4'b0010, 1'b1);
        run_txn(2'd1, 26'h0F0F0F0, -1, -1);

        // Edge data: all ones then all zeros
        wait_grant(4'b0001, 1'b1);
        run_txn(2'd0, 26'h3FFFFFF, -1, -1);
        wait_grant(4'b0001, 1'b1);
        run_txn(2'd0, 26'h0000000, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
